// File: rtl/watch_hhmmss_set_if.sv
// Button/format inputs and display outputs of the HH:MM:SS watch core.
// The master drives the buttons, the slave drives the display.
interface watch_hhmmss_set_if;
  logic       mode_btn_i;
  logic       inc_btn_i;
  logic       fmt12_i;
  logic [6:0] segment_hxxxxx;
  logic [6:0] segment_xhxxxx;
  logic [6:0] segment_xxmxxx;
  logic [6:0] segment_xxxmxx;
  logic [6:0] segment_xxxxsx;
  logic [6:0] segment_xxxxxs;
  logic       pm_o;
  logic       set_mode_o;

  modport master (
    output mode_btn_i, inc_btn_i, fmt12_i,
    input  segment_hxxxxx, segment_xhxxxx, segment_xxmxxx,
    input  segment_xxxmxx, segment_xxxxsx, segment_xxxxxs, pm_o, set_mode_o
  );

  modport slave (
    input  mode_btn_i, inc_btn_i, fmt12_i,
    output segment_hxxxxx, segment_xhxxxx, segment_xxmxxx,
    output segment_xxxmxx, segment_xxxxsx, segment_xxxxxs, pm_o, set_mode_o
  );
endinterface

// File: rtl/watch_hhmmss_set.sv
// HH:MM:SS watch with two-button set mode, blinking edit field and 12h/24h
// seven-segment display. Counters are BCD and always 24h.
module watch_hhmmss_set #(
  parameter int unsigned CLK_FREQ = 32768,
  parameter bit          HOUR_LZB = 1'b0
) (
  input logic               clk_i,
  input logic               rst_i,
  watch_hhmmss_set_if.slave bus
);
  localparam int unsigned    PW       = $clog2(CLK_FREQ);
  localparam logic [PW-1:0]  PresLast = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0]  PresHalf = PW'(CLK_FREQ / 2);
  localparam logic [1:0]     StRun    = 2'd0;
  localparam logic [1:0]     StSetHh  = 2'd1;
  localparam logic [1:0]     StSetMm  = 2'd2;
  localparam logic [6:0]     SegZero  = 7'h3f;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    sec_t_q, sec_t_d, min_t_q, min_t_d;
  logic [3:0]    sec_u_q, sec_u_d, min_u_q, min_u_d, hr_u_q, hr_u_d;
  logic [1:0]    hr_t_q, hr_t_d;
  logic [2:0]    mode_sync_q, inc_sync_q;
  logic [6:0]    seg_q [6];
  logic [6:0]    seg_d [6];
  logic          pm_q, pm_d, set_q, set_d;

  logic mode_edge, inc_edge, sec_tick, blink;
  assign mode_edge = mode_sync_q[1] & ~mode_sync_q[2];
  assign inc_edge  = inc_sync_q[1] & ~inc_sync_q[2];
  assign sec_tick  = (presc_q == PresLast);
  assign blink     = (presc_q >= PresHalf);

  function automatic logic [6:0] bcd60_inc(input logic [2:0] t, input logic [3:0] u);
    if (u == 4'd9) return (t == 3'd5) ? 7'd0 : {t + 3'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  function automatic logic [5:0] hour_inc(input logic [1:0] t, input logic [3:0] u);
    if (t == 2'd2 && u == 4'd3) return 6'd0;
    if (u == 4'd9) return {t + 2'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3f;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5b;
      4'd3:    return 7'h4f;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6d;
      4'd6:    return 7'h7d;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7f;
      4'd9:    return 7'h6f;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    presc_d = sec_tick ? '0 : presc_q + PW'(1);
    {sec_t_d, sec_u_d} = {sec_t_q, sec_u_q};
    {min_t_d, min_u_d} = {min_t_q, min_u_q};
    {hr_t_d, hr_u_d}   = {hr_t_q, hr_u_q};
    case (state_q)
      StRun: begin
        if (mode_edge) begin
          state_d = StSetHh;
          {sec_t_d, sec_u_d} = 7'd0;
        end else if (sec_tick) begin
          {sec_t_d, sec_u_d} = bcd60_inc(sec_t_q, sec_u_q);
          if (sec_t_q == 3'd5 && sec_u_q == 4'd9) begin
            {min_t_d, min_u_d} = bcd60_inc(min_t_q, min_u_q);
            if (min_t_q == 3'd5 && min_u_q == 4'd9) begin
              {hr_t_d, hr_u_d} = hour_inc(hr_t_q, hr_u_q);
            end
          end
        end
      end
      StSetHh: begin
        if (mode_edge)     state_d = StSetMm;
        else if (inc_edge) {hr_t_d, hr_u_d} = hour_inc(hr_t_q, hr_u_q);
      end
      StSetMm: begin
        if (mode_edge) begin
          // Restart the second so the first tick lands a full second later.
          state_d = StRun;
          {sec_t_d, sec_u_d} = 7'd0;
          presc_d = '0;
        end else if (inc_edge) begin
          {min_t_d, min_u_d} = bcd60_inc(min_t_q, min_u_q);
        end
      end
      default: state_d = StRun;
    endcase
  end

  logic [4:0] hour_bin, h12;
  logic [3:0] disp_ht, disp_hu;

  always_comb begin
    hour_bin = 5'(hr_t_q) * 5'd10 + 5'(hr_u_q);
    h12      = hour_bin;
    pm_d     = 1'b0;
    disp_ht  = {2'b00, hr_t_q};
    disp_hu  = hr_u_q;
    if (bus.fmt12_i) begin
      if (hour_bin == 5'd0)       h12 = 5'd12;
      else if (hour_bin > 5'd12)  h12 = hour_bin - 5'd12;
      pm_d    = (hour_bin >= 5'd12);
      disp_ht = (h12 >= 5'd10) ? 4'd1 : 4'd0;
      disp_hu = (h12 >= 5'd10) ? 4'(h12 - 5'd10) : 4'(h12);
    end
    seg_d[5] = (HOUR_LZB && disp_ht == 4'd0) ? 7'h00 : seg7(disp_ht);
    seg_d[4] = seg7(disp_hu);
    seg_d[3] = seg7({1'b0, min_t_q});
    seg_d[2] = seg7(min_u_q);
    seg_d[1] = seg7({1'b0, sec_t_q});
    seg_d[0] = seg7(sec_u_q);
    if (blink && state_q == StSetHh) begin
      seg_d[5] = 7'h00;
      seg_d[4] = 7'h00;
    end
    if (blink && state_q == StSetMm) begin
      seg_d[3] = 7'h00;
      seg_d[2] = 7'h00;
    end
    set_d = (state_q == StSetHh) || (state_q == StSetMm);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      presc_q     <= '0;
      sec_t_q     <= '0;
      sec_u_q     <= '0;
      min_t_q     <= '0;
      min_u_q     <= '0;
      hr_t_q      <= '0;
      hr_u_q      <= '0;
      mode_sync_q <= '0;
      inc_sync_q  <= '0;
      seg_q[5]    <= HOUR_LZB ? 7'h00 : SegZero;
      for (int i = 0; i < 5; i++) seg_q[i] <= SegZero;
      pm_q        <= 1'b0;
      set_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_t_q     <= sec_t_d;
      sec_u_q     <= sec_u_d;
      min_t_q     <= min_t_d;
      min_u_q     <= min_u_d;
      hr_t_q      <= hr_t_d;
      hr_u_q      <= hr_u_d;
      mode_sync_q <= {mode_sync_q[1:0], bus.mode_btn_i};
      inc_sync_q  <= {inc_sync_q[1:0], bus.inc_btn_i};
      for (int i = 0; i < 6; i++) seg_q[i] <= seg_d[i];
      pm_q        <= pm_d;
      set_q       <= set_d;
    end
  end

  assign bus.segment_hxxxxx = seg_q[5];
  assign bus.segment_xhxxxx = seg_q[4];
  assign bus.segment_xxmxxx = seg_q[3];
  assign bus.segment_xxxmxx = seg_q[2];
  assign bus.segment_xxxxsx = seg_q[1];
  assign bus.segment_xxxxxs = seg_q[0];
  assign bus.pm_o           = pm_q;
  assign bus.set_mode_o     = set_q;
endmodule

// File: tb/tb_watch_hhmmss_set.sv
// Directed bench for watch_hhmmss_set at CLK_FREQ=4: run/display table plus
// hand sequences for set mode, wraps, blink, held buttons and async reset.
module tb_watch_hhmmss_set;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  watch_hhmmss_set_if bus ();

  watch_hhmmss_set #(
    .CLK_FREQ(4),
    .HOUR_LZB(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the prescaler equals cyc mod 4 until SET_MM -> RUN.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int adv;
    bit fmt;
    int h;
    int m;
    int s;
    bit pm;
  } vec_t;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3f;  1: return 7'h06;  2: return 7'h5b;  3: return 7'h4f;
      4: return 7'h66;  5: return 7'h6d;  6: return 7'h7d;  7: return 7'h07;
      8: return 7'h7f;  9: return 7'h6f;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [43:0] model(input int h, input int m, input int s, input bit pm,
                                        input bit set, input bit bh, input bit bm);
    logic [6:0] ht, hu, mt, mu;
    ht = bh ? 7'h00 : seg(h / 10);
    hu = bh ? 7'h00 : seg(h % 10);
    mt = bm ? 7'h00 : seg(m / 10);
    mu = bm ? 7'h00 : seg(m % 10);
    return {ht, hu, mt, mu, seg(s / 10), seg(s % 10), pm, set};
  endfunction

  task automatic check(input string name, input logic [43:0] exp);
    logic [43:0] got;
    got = {bus.segment_hxxxxx, bus.segment_xhxxxx, bus.segment_xxmxxx, bus.segment_xxxmxx,
           bus.segment_xxxxsx, bus.segment_xxxxxs, bus.pm_o, bus.set_mode_o};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got segs/pm/set %h required %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    check("reset_hold", model(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
  endtask

  task automatic press(input bit is_mode);
    if (is_mode) bus.mode_btn_i = 1'b1;
    else         bus.inc_btn_i = 1'b1;
    tick(3);
    bus.mode_btn_i = 1'b0;
    bus.inc_btn_i  = 1'b0;
    tick(3);
  endtask

  task automatic press_n(input bit is_mode, input int n);
    for (int i = 0; i < n; i++) press(is_mode);
  endtask

  // Waits (bounded) for the blinking field to be shown.
  task automatic wait_vis(input bit hours);
    int n = 0;
    while (n < 5 && (hours ? (bus.segment_hxxxxx == 7'h00 && bus.segment_xhxxxx == 7'h00)
                           : (bus.segment_xxmxxx == 7'h00 && bus.segment_xxxmxx == 7'h00))) begin
      tick(1);
      n++;
    end
  endtask

  vec_t vecs[8];

  initial begin
    bus.mode_btn_i = 1'b0;
    bus.inc_btn_i  = 1'b0;
    bus.fmt12_i    = 1'b0;

    // Free run from reset, displayed values lag the counters by one edge.
    vecs[0] = '{1, 1'b0, 0, 0, 0, 1'b0};
    vecs[1] = '{4, 1'b0, 0, 0, 1, 1'b0};
    vecs[2] = '{1, 1'b1, 12, 0, 1, 1'b0};
    vecs[3] = '{1, 1'b0, 0, 0, 1, 1'b0};
    vecs[4] = '{32, 1'b0, 0, 0, 9, 1'b0};
    vecs[5] = '{4, 1'b0, 0, 0, 10, 1'b0};
    vecs[6] = '{202, 1'b0, 0, 1, 1, 1'b0};
    vecs[7] = '{1, 1'b1, 12, 1, 1, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.fmt12_i = vecs[i].fmt;
      tick(vecs[i].adv);
      check($sformatf("run_vec%0d", i),
            model(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].pm, 1'b0, 1'b0, 1'b0));
    end
    bus.fmt12_i = 1'b0;

    // Set 05:02 and check the first second after leaving set mode.
    do_reset();
    press(1'b1);
    press_n(1'b0, 5);
    press(1'b1);
    press_n(1'b0, 2);
    bus.mode_btn_i = 1'b1;
    tick(3);
    bus.mode_btn_i = 1'b0;
    tick(1);
    check("set_exit", model(5, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(3);
    check("first_sec_not_yet", model(5, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(1);
    check("first_sec", model(5, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0));

    // Blink of the hour field, then a 20-cycle held inc.
    do_reset();
    press(1'b1);
    press_n(1'b0, 3);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("blink%0d", i),
            model(3, 0, 0, 1'b0, 1'b1, (((cyc - 1) % 4) >= 2), 1'b0));
    end
    bus.inc_btn_i = 1'b1;
    tick(20);
    bus.inc_btn_i = 1'b0;
    tick(3);
    wait_vis(1'b1);
    check("held_inc", model(4, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0));

    // 23:59 through midnight in 12h then 24h.
    do_reset();
    press(1'b1);
    press_n(1'b0, 23);
    press(1'b1);
    press_n(1'b0, 59);
    bus.fmt12_i = 1'b1;
    bus.mode_btn_i = 1'b1;
    tick(3);
    bus.mode_btn_i = 1'b0;
    tick(240);
    check("pre_wrap_12h", model(11, 59, 59, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(1);
    check("wrap_12h", model(12, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.fmt12_i = 1'b0;
    tick(1);
    check("wrap_24h", model(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Field wraps without carry.
    press(1'b1);
    press_n(1'b0, 23);
    wait_vis(1'b1);
    check("hour23", model(23, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
    press(1'b1);
    press_n(1'b0, 59);
    wait_vis(1'b0);
    check("min59", model(23, 59, 0, 1'b0, 1'b1, 1'b0, 1'b0));
    press(1'b0);
    wait_vis(1'b0);
    check("min_wrap", model(23, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
    press(1'b1);
    press(1'b1);
    press(1'b0);
    wait_vis(1'b1);
    check("hour_wrap", model(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0));

    // Mode and inc together in SET_HH: mode wins.
    bus.mode_btn_i = 1'b1;
    bus.inc_btn_i  = 1'b1;
    tick(3);
    bus.mode_btn_i = 1'b0;
    bus.inc_btn_i  = 1'b0;
    tick(3);
    wait_vis(1'b0);
    check("mode_wins", model(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0));

    // Asynchronous reset in SET_MM, mid-cycle.
    press_n(1'b0, 7);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", model(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(2);
    rst = 1'b0;
    tick(1);
    check("after_reset", model(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/watch_hhmmss_set.md
Name: watch_hhmmss_set

Overview:
- Parametrised successor to the HH:MM watch core.
- Keeps time as HH:MM:SS from a free-running input clock of configurable frequency.
- Drives six 7-segment digits, with selectable 12h/24h display.
- Two-button set mode: hours and minutes can be edited, and the field being edited blinks.
- Sits between the crystal clock domain and the pad-level segment drivers.

Parameters:
CLK_FREQ, 32768, input clock cycles per second (>=4, even); benches use 4.
HOUR_LZB, 0, 1 = blank hour-tens digit when it is zero.

Ports:
clk_i  in  1  clock, CLK_FREQ Hz
rst_i  in  1  asynchronous active-high reset
mode_btn_i  in  1  mode button level (asynchronous)
inc_btn_i  in  1  increment button level (asynchronous)
fmt12_i  in  1  1 = 12h display, 0 = 24h display (quasi-static)
segment_hxxxxx  out  7  hour tens
segment_xhxxxx  out  7  hour units
segment_xxmxxx  out  7  minute tens
segment_xxxmxx  out  7  minute units
segment_xxxxsx  out  7  second tens
segment_xxxxxs  out  7  second units
pm_o  out  1  PM indicator (12h mode only, else 0)
set_mode_o  out  1  high in SET_HH or SET_MM

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset state (immediately on rst_i high):
  - time = 00:00:00, prescaler = 0, FSM = RUN.
  - All six segment outputs = 7'b0111111 ("0"). Hour-tens is 0 if HOUR_LZB=1; in 12h mode the display shows 12 after the first clock.
  - pm_o = 0, set_mode_o = 0.
- Segment encoding:
  - Bit order {g,f,e,d,c,b,a}, active high.
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; blank = 00.
- Prescaler:
  - Counts 0..CLK_FREQ-1 and wraps.
  - sec_tick is a one-cycle pulse when the count = CLK_FREQ-1, acted on only in RUN.
- Time counters:
  - BCD: sec 00-59, min 00-59, hour 00-23.
  - On sec_tick, carries ripple in the same edge: 23:59:59 -> 00:00:00.
- Outputs:
  - Segments, pm_o and set_mode_o are registered: 1-cycle latency after any counter or FSM change.
  - 12h mapping: hour 0 -> 12 with pm=0; 1-11 -> same with pm=0; 12 -> 12 with pm=1; 13-23 -> h-12 with pm=1.
  - Counters are always 24h. fmt12_i affects display only, taking effect 1 cycle after it changes.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then rising-edge detection.
  - A level first sampled high at edge k gives an action at edge k+2 and the display at edge k+3.
  - Holding a button produces exactly one action; a new action needs release and re-press.
- FSM (RUN, SET_HH, SET_MM):
  - mode edge: RUN -> SET_HH -> SET_MM -> RUN.
  - On entry to SET_HH: sec cleared to 00.
  - On SET_MM -> RUN: sec = 00 and prescaler = 0, so the first tick comes exactly CLK_FREQ cycles later.
  - inc edge in SET_HH: hour+1 mod 24 (23 -> 00). In SET_MM: min+1 mod 60. No carry into other fields.
  - inc edge in RUN: ignored.
  - mode and inc edges in the same cycle: mode wins, inc discarded.
  - In SET states, sec_tick is ignored and time does not advance; the prescaler keeps running for blink.
- Blink:
  - In SET_HH the two hour digits are blanked, and in SET_MM the two minute digits, while prescaler >= CLK_FREQ/2.
  - All other digits display normally.
- Reset mid-set: returns to RUN and 00:00:00 immediately; synchroniser flops clear to 0.

Test Plan:
1. Reset and run, CLK_FREQ=4:
   - Stimulus: rst_i high 2 cycles then low, run 4*61 cycles.
   - Required: the segment outputs read 00:01:01 (3F,3F,3F,06,3F,06).
   - Required: during reset all segment outputs = 3F and set_mode_o = 0.
2. Wrap:
   - Stimulus: set 23:59 via buttons, exit to RUN, run 4*60 cycles.
   - Required: 00:00:00 displayed.
   - Required: 12h mode shows 12:00:00 with pm_o 1 -> 0 at the wrap.
3. Set mode:
   - Stimulus: mode press, 5 inc presses, mode press, 2 inc presses, mode press.
   - Required: hour 05, min 02, sec 00, set_mode_o = 0.
   - Required: the next second increments exactly 4 cycles after the FSM enters RUN.
4. Field wrap without carry:
   - Stimulus: in SET_MM at min 59, one inc.
   - Required: min = 00, hour unchanged.
   - Required: in SET_HH at hour 23, one inc gives hour = 00.
5. Blink and hold:
   - Stimulus: in SET_HH, observe 8 cycles.
   - Required: hour digits = 00 for prescaler 2..3 and valid for 0..1; other digits stay steady.
   - Stimulus: inc held 20 cycles.
   - Required: exactly one increment.
6. Simultaneous events and async reset:
   - Stimulus: mode and inc rise in the same cycle in SET_HH.
   - Required: FSM -> SET_MM, hour unchanged.
   - Stimulus: assert rst_i mid-cycle in SET_MM.
   - Required: outputs go to reset values without waiting for a clock edge.
